arilla_timer_responder: RTL and testbench
=========================================

// Module: arilla_timer_responder
// PURPOSE
//  Responder-side (peripheral) endpoint of the Arilla bus: a memory-mapped machine timer.
//  Holds a 64-bit mtime counter (prescaled), a 64-bit mtimecmp and a level timer interrupt.
//  Connects to the CPU's arilla_bus_if alongside memories; stop_count freezes time while the
//  hart is halted in debug mode (dcsr.stoptime).
// PARAMETERS
//  DataWidth        32            bus data width; block supports 32 only (elab assert)
//  ByteAddressWidth 32            bus byte-address width
//  ByteSize         8             bits per byte_enable lane
//  BaseAddress      32'hFFFF_0000 byte base of 8-word window; 32-byte aligned (elab assert)
//  PrescaleWidth    16            width of prescale register, 1..32
// PORTS
//  clk         input   1   system clock, all state on rising edge
//  rst_n       input   1   synchronous active-low reset
//  bus         iface   -   arilla_bus_if; drives hit/data_ptc; reads address/byte_enable/data_ctp/read/write/inhibit/intercept
//  stop_count  input   1   1 = freeze prescaler and mtime (debug halt)
//  irq_timer   output  1   registered level interrupt, 1 while mtime >= mtimecmp
// BEHAVIOUR
//  Map, word offset = address[2:0] within window: 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0],
//   3 mtimecmp[63:32], 4 prescale (zero-extended), 5 ctrl {bit1 irq_timer RO, bit0 enable RW}, 6-7 reserved.
//  sel = (read|write) & address[WordAddressWidth-1:3]==BaseAddress word>>3 & ~intercept.
//  hit: drive 1 when sel, else 'z (tri0 pull gives 0). Never drive 0.
//  data_ptc: drive read data when read & sel, else 'z. Combinational, zero wait states, same cycle.
//   Reserved offsets and unused bits read 0; reserved offsets still assert hit.
//  Write commits at clk edge when write & sel & ~inhibit; only lanes with byte_enable=1 update.
//   inhibit: hit/data still driven, no state change. intercept: fully released, no state change.
//  read & write same cycle: data_ptc shows pre-write values, write commits at edge.
//  Writes to ctrl bit1 and reserved offsets ignored.
//  Prescaler: pcnt (PrescaleWidth bits) advances when enable & ~stop_count; on pcnt==prescale
//   pcnt<=0 and mtime<=mtime+1 (64-bit, wraps to 0). prescale=0 -> tick every enabled cycle.
//   Disable or stop_count: pcnt and mtime hold (no clear).
//  Write to offset 0 or 1: written lanes take write data; mtime tick suppressed that cycle;
//   pcnt advances normally. Write to offset 4: pcnt<=0 same edge.
//  irq_timer <= (mtime >= mtimecmp), unsigned 64-bit, using current register values:
//   one cycle after the compare becomes true or false. No stop/enable gating of compare.
//  Reset (rst_n=0 at edge): mtime=0, mtimecmp=all ones, prescale=0, enable=0, pcnt=0, irq_timer=0.
//   Bus decode stays combinational during reset; a write during reset is discarded.
// TESTING
//  1 Reset, read offsets 0-5 -> 0,0,FFFFFFFF,FFFFFFFF,0,0; hit=1; out-of-window read -> hit=0, data_ptc undriven (all 1s).
//  2 prescale=3, enable=1, 40 cycles -> mtime=10; assert stop_count 8 cycles -> mtime holds, pcnt resumes exactly.
//  3 mtime_lo=FFFFFFFE, hi=0, prescale=0, enable -> after 2 ticks hi=1, lo=0; from all ones -> wraps to 0.
//  4 mtimecmp=5, prescale=0, enable -> irq_timer rises 1 cycle after mtime==5; mtimecmp_lo write 100 -> falls next cycle.
//  5 byte_enable=4'b0010 write 0xAABBCCDD to mtimecmp_lo -> reads FFFFCCFF; same write with inhibit=1 -> unchanged, hit=1.
//  6 Write with intercept=1 -> hit/data_ptc undriven, no change; read+write same cycle -> old data returned, new stored.

Source files
------------

// File: rtl/arilla_timer_responder.sv
// arilla_timer_responder
//   Memory-mapped machine timer sitting on the Arilla bus as a responder.
//   Holds a prescaled 64-bit mtime, a 64-bit mtimecmp and a registered level
//   timer interrupt. Eight-word window at BaseAddress:
//     0 mtime[31:0]     1 mtime[63:32]    2 mtimecmp[31:0]  3 mtimecmp[63:32]
//     4 prescale        5 ctrl {bit1 irq_timer RO, bit0 enable RW}   6-7 reserved
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   bus_address       word address (byte address >> 2)
//   bus_byte_enable   write lane enables
//   bus_data_ctp      write data (controller to peripheral)
//   bus_read/write    transfer strobes
//   bus_inhibit       keep responding but suppress state change
//   bus_intercept     another agent owns the cycle; release the bus entirely
//   bus_hit           1 when selected, otherwise released (board pull-down gives 0)
//   bus_data_ptc      read data when selected for read, otherwise released
//   stop_count        freeze prescaler and mtime (debug halt)
//   irq_timer         1 while mtime >= mtimecmp, one cycle behind the compare
module arilla_timer_responder #(
  parameter int unsigned DataWidth        = 32,
  parameter int unsigned ByteAddressWidth = 32,
  parameter int unsigned ByteSize         = 8,
  parameter logic [ByteAddressWidth-1:0] BaseAddress = 32'hFFFF_0000,
  parameter int unsigned PrescaleWidth    = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [ByteAddressWidth-$clog2(DataWidth/8)-1:0]       bus_address,
  input  logic [DataWidth/ByteSize-1:0]                         bus_byte_enable,
  input  logic [DataWidth-1:0]                                  bus_data_ctp,
  input  logic                                                  bus_read,
  input  logic                                                  bus_write,
  input  logic                                                  bus_inhibit,
  input  logic                                                  bus_intercept,
  output logic                                                  bus_hit,
  output logic [DataWidth-1:0]                                  bus_data_ptc,
  input  logic                                                  stop_count,
  output logic                                                  irq_timer
);

  localparam int unsigned OffBits = $clog2(DataWidth/8);
  localparam int unsigned WordAw  = ByteAddressWidth - OffBits;
  localparam int unsigned Lanes   = DataWidth / ByteSize;
  localparam logic [WordAw-4:0] WinTag = BaseAddress[ByteAddressWidth-1:OffBits+3];

  if (DataWidth != 32) begin : g_dw_check
    $error("arilla_timer_responder supports DataWidth=32 only");
  end
  if (BaseAddress[4:0] != 5'd0) begin : g_base_check
    $error("arilla_timer_responder BaseAddress must be 32-byte aligned");
  end
  if (PrescaleWidth < 1 || PrescaleWidth > 32) begin : g_pw_check
    $error("arilla_timer_responder PrescaleWidth must be 1..32");
  end

  logic [63:0]              mtime;
  logic [63:0]              mtimecmp;
  logic [PrescaleWidth-1:0] prescale;
  logic [PrescaleWidth-1:0] pcnt;
  logic                     enable;

  logic                 sel;
  logic                 wr_en;
  logic [2:0]           offset;
  logic [DataWidth-1:0] rdata;
  logic                 run;
  logic                 tick;
  logic                 mtime_wr;

  function automatic logic [DataWidth-1:0] merge(input logic [DataWidth-1:0] old,
                                                 input logic [DataWidth-1:0] wd,
                                                 input logic [Lanes-1:0]     be);
    merge = old;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (be[i]) merge[i*ByteSize +: ByteSize] = wd[i*ByteSize +: ByteSize];
    end
  endfunction

  assign offset = bus_address[2:0];
  assign sel    = (bus_read | bus_write) & (bus_address[WordAw-1:3] == WinTag) & ~bus_intercept;
  assign wr_en  = bus_write & sel & ~bus_inhibit;

  always_comb begin
    rdata = '0;
    case (offset)
      3'd0:    rdata = mtime[31:0];
      3'd1:    rdata = mtime[63:32];
      3'd2:    rdata = mtimecmp[31:0];
      3'd3:    rdata = mtimecmp[63:32];
      3'd4:    rdata = 32'(prescale);
      3'd5:    rdata = {30'd0, irq_timer, enable};
      default: rdata = '0;
    endcase
  end

  // Responder only ever drives 1 on hit; released otherwise.
  assign bus_hit      = sel ? 1'b1 : 1'bz;
  assign bus_data_ptc = (bus_read & sel) ? rdata : 'z;

  assign run      = enable & ~stop_count;
  assign tick     = run & (pcnt == prescale);
  // A software write to either mtime half wins over the tick for the whole
  // 64-bit counter, so no carry leaks into the half that was not written.
  assign mtime_wr = wr_en & (offset == 3'd0 || offset == 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      prescale  <= '0;
      pcnt      <= '0;
      enable    <= 1'b0;
      irq_timer <= 1'b0;
    end else begin
      irq_timer <= (mtime >= mtimecmp);

      if (run) pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick && !mtime_wr) mtime <= mtime + 64'd1;

      if (wr_en) begin
        case (offset)
          3'd0: mtime[31:0]     <= merge(mtime[31:0], bus_data_ctp, bus_byte_enable);
          3'd1: mtime[63:32]    <= merge(mtime[63:32], bus_data_ctp, bus_byte_enable);
          3'd2: mtimecmp[31:0]  <= merge(mtimecmp[31:0], bus_data_ctp, bus_byte_enable);
          3'd3: mtimecmp[63:32] <= merge(mtimecmp[63:32], bus_data_ctp, bus_byte_enable);
          3'd4: begin
            prescale <= PrescaleWidth'(merge(32'(prescale), bus_data_ctp, bus_byte_enable));
            pcnt     <= '0;
          end
          3'd5: if (bus_byte_enable[0]) enable <= bus_data_ctp[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arilla_timer_responder.sv
// Self-checking bench for arilla_timer_responder: bus reads are scored
// against a queue of expected words; counter, interrupt and bus-release
// behaviour checked at fixed cycle counts.
module tb_arilla_timer_responder;

  localparam logic [29:0] Base = 30'h3FFF_C000;  // 32'hFFFF_0000 >> 2

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] address;
  logic [3:0]  byte_enable;
  logic [31:0] data_ctp;
  logic        read, write, inhibit, intercept, stop_count;
  tri0         hit;
  tri1  [31:0] data_ptc;
  logic        irq_timer;

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arilla_timer_responder #(
    .DataWidth       (32),
    .ByteAddressWidth(32),
    .ByteSize        (8),
    .BaseAddress     (32'hFFFF_0000),
    .PrescaleWidth   (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus_address    (address),
    .bus_byte_enable(byte_enable),
    .bus_data_ctp   (data_ctp),
    .bus_read       (read),
    .bus_write      (write),
    .bus_inhibit    (inhibit),
    .bus_intercept  (intercept),
    .bus_hit        (hit),
    .bus_data_ptc   (data_ptc),
    .stop_count     (stop_count),
    .irq_timer      (irq_timer)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    read        = 1'b0;
    write       = 1'b0;
    inhibit     = 1'b0;
    intercept   = 1'b0;
    byte_enable = '0;
    data_ctp    = '0;
    address     = Base + 30'd8;
  endtask

  // Pop the oldest expected word and score the data the DUT is driving now.
  task automatic score();
    exp_t e;
    check("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, 64'(data_ptc), 64'(e.data));
    end
  endtask

  // All bus tasks start at a negedge and consume exactly one rising edge.
  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] be = 4'hF);
    address     = Base + 30'(off);
    write       = 1'b1;
    data_ctp    = d;
    byte_enable = be;
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
    address = Base + 30'(off);
    read    = 1'b1;
    sb.push_back('{tag, exp});
    #1;
    score();
    check({tag, "_hit"}, 64'(hit), 64'd1);
    @(negedge clk);
    idle();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    stop_count = 1'b0;
    rst_n      = 1'b0;

    // 1: reset values; a write attempted during reset is discarded
    address     = Base + 30'd4;
    write       = 1'b1;
    data_ctp    = 32'd7;
    byte_enable = 4'hF;
    wait_cycles(3);
    idle();
    rst_n = 1'b1;
    check("rst_irq", 64'(irq_timer), 64'd0);
    rd("rst_mtime_lo", 3'd0, 32'h0000_0000);
    rd("rst_mtime_hi", 3'd1, 32'h0000_0000);
    rd("rst_cmp_lo",   3'd2, 32'hFFFF_FFFF);
    rd("rst_cmp_hi",   3'd3, 32'hFFFF_FFFF);
    rd("rst_prescale", 3'd4, 32'h0000_0000);
    rd("rst_ctrl",     3'd5, 32'h0000_0000);
    rd("reserved6",    3'd6, 32'h0000_0000);
    wr(3'd5, 32'h0000_0002);
    rd("ctrl_ro_bit",  3'd5, 32'h0000_0000);
    address = Base + 30'd8;
    read    = 1'b1;
    #1;
    check("oow_hit",  64'(hit), 64'd0);
    check("oow_data", 64'(data_ptc), 64'hFFFF_FFFF);
    @(negedge clk);
    idle();

    // 2: prescale 3 gives one tick per 4 enabled cycles; stop_count freezes
    do_reset();
    wr(3'd4, 32'd3);
    wr(3'd5, 32'd1);
    wait_cycles(40);
    rd("pre_mtime_40", 3'd0, 32'd10);   // this edge moves pcnt to 1
    stop_count = 1'b1;
    wait_cycles(8);
    rd("stop_hold", 3'd0, 32'd10);
    stop_count = 1'b0;
    wait_cycles(2);                     // pcnt 1 -> 3
    rd("resume_pre", 3'd0, 32'd10);     // this edge ticks
    rd("resume_tick", 3'd0, 32'd11);

    // 3: carry into the high word and 64-bit wrap
    do_reset();
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd1, 32'h0000_0000);
    wr(3'd5, 32'd1);
    wait_cycles(2);
    rd("carry_lo", 3'd0, 32'h0000_0000);
    rd("carry_hi", 3'd1, 32'h0000_0001);
    wr(3'd5, 32'd0);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd5, 32'd1);
    wait_cycles(1);
    rd("wrap_lo", 3'd0, 32'h0000_0000);
    rd("wrap_hi", 3'd1, 32'h0000_0000);

    // 4: interrupt timing around mtime == mtimecmp
    do_reset();
    wr(3'd2, 32'd5);
    wr(3'd3, 32'd0);
    wr(3'd5, 32'd1);
    wait_cycles(5);
    check("irq_at_eq", 64'(irq_timer), 64'd0);
    wait_cycles(1);
    check("irq_rise", 64'(irq_timer), 64'd1);
    wr(3'd2, 32'd100);
    check("irq_hold", 64'(irq_timer), 64'd1);
    wait_cycles(1);
    check("irq_fall", 64'(irq_timer), 64'd0);

    // 5: byte lanes and inhibit
    do_reset();
    wr(3'd2, 32'hAABB_CCDD, 4'b0010);
    rd("lane_write", 3'd2, 32'hFFFF_CCFF);
    address     = Base + 30'd2;
    read        = 1'b1;
    write       = 1'b1;
    inhibit     = 1'b1;
    data_ctp    = 32'h1122_3344;
    byte_enable = 4'hF;
    sb.push_back('{"inhibit_data", 32'hFFFF_CCFF});
    #1;
    score();
    check("inhibit_hit", 64'(hit), 64'd1);
    @(negedge clk);
    idle();
    rd("inhibit_nochg", 3'd2, 32'hFFFF_CCFF);

    // 6: intercept releases the bus; read+write returns old data
    address     = Base + 30'd2;
    read        = 1'b1;
    write       = 1'b1;
    intercept   = 1'b1;
    data_ctp    = 32'h0000_0000;
    byte_enable = 4'hF;
    #1;
    check("icpt_hit",  64'(hit), 64'd0);
    check("icpt_data", 64'(data_ptc), 64'hFFFF_FFFF);
    @(negedge clk);
    idle();
    rd("icpt_nochg", 3'd2, 32'hFFFF_CCFF);
    address     = Base + 30'd2;
    read        = 1'b1;
    write       = 1'b1;
    data_ctp    = 32'h1234_5678;
    byte_enable = 4'hF;
    sb.push_back('{"rw_old", 32'hFFFF_CCFF});
    #1;
    score();
    @(negedge clk);
    idle();
    rd("rw_new", 3'd2, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
